// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: FSM states,
// instruction fields, ALU operation codes and datapath mux selects.
package mcpu_pkg;

  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_MA  = 4'd2,
    S_MRD = 4'd3,
    S_LWB = 4'd4,
    S_MWR = 4'd5,
    S_REX = 4'd6,
    S_RWB = 4'd7,
    S_BEX = 4'd8,
    S_JMP = 4'd9,
    S_IEX = 4'd10,
    S_IWB = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_XOR = 6'b100110;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b011;

  // ALUop: what the FSM asks the ALU decoder for.
  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;
  localparam logic [1:0] AOP_SLT   = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: maps the FSM's ALUop and the R-type funct field to a
// 3-bit ALU operation, and flags whether the funct is one we implement.
module alu_ctrl_dec
  import mcpu_pkg::*;
(
  input  logic [1:0] ALUop_i,
  input  logic [5:0] Fun_i,
  output logic [2:0] ALU_Control_o,
  output logic       funct_valid_o
);

  logic [2:0] fn_code;

  // funct_valid is independent of ALUop so ID can flag a bad funct early.
  always_comb begin
    fn_code       = 3'b000;
    funct_valid_o = 1'b1;
    case (Fun_i)
      FN_ADD:  fn_code = ALU_ADD;
      FN_SUB:  fn_code = ALU_SUB;
      FN_AND:  fn_code = ALU_AND;
      FN_OR:   fn_code = ALU_OR;
      FN_SLT:  fn_code = ALU_SLT;
      FN_NOR:  fn_code = ALU_NOR;
      FN_SRL:  fn_code = ALU_SRL;
      FN_XOR:  fn_code = ALU_XOR;
      default: funct_valid_o = 1'b0;
    endcase
  end

  always_comb begin
    case (ALUop_i)
      AOP_ADD:   ALU_Control_o = ALU_ADD;
      AOP_SUB:   ALU_Control_o = ALU_SUB;
      AOP_FUNCT: ALU_Control_o = fn_code;
      default:   ALU_Control_o = ALU_SLT;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle control FSM: sequences IF/ID/EX/MEM/WB steps over a shared
// memory port and ALU, driving the datapath enables and mux selects.
module mcpu_ctrl_fsm
  import mcpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OPcode,
  input  logic [5:0] Fun,
  input  logic       zero,
  input  logic       MIO_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       CPU_MIO,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALU_Control,
  output logic       illegal_inst,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic       alu_act;
  logic [2:0] alu_code;
  logic       funct_valid;
  logic       pc_wr, pc_wr_cond, ir_wr, reg_wr, mem_wr, mem_rd, mio_req;

  // zero is combined with PCWriteCond in the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  alu_ctrl_dec u_alu_dec (
    .ALUop_i       (alu_op),
    .Fun_i         (Fun),
    .ALU_Control_o (alu_code),
    .funct_valid_o (funct_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    pc_wr        = 1'b0;
    pc_wr_cond   = 1'b0;
    ir_wr        = 1'b0;
    reg_wr       = 1'b0;
    mem_wr       = 1'b0;
    mem_rd       = 1'b0;
    mio_req      = 1'b0;
    IorD         = 1'b0;
    ALUSrcA      = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    ALUSrcB      = SRCB_REG;
    PCSource     = PCSRC_ALU;
    alu_op       = AOP_ADD;
    alu_act      = 1'b0;
    illegal_inst = 1'b0;
    case (state_q)
      S_IF: begin
        mem_rd  = 1'b1;
        mio_req = 1'b1;
        ALUSrcB = SRCB_FOUR;
        alu_act = 1'b1;
        ir_wr   = MIO_ready;
        pc_wr   = MIO_ready;
        if (MIO_ready) state_d = S_ID;
      end
      S_ID: begin
        ALUSrcB = SRCB_IMM_SH2;
        alu_act = 1'b1;
        case (OPcode)
          OP_LW, OP_SW:     state_d = S_MA;
          OP_BEQ:           state_d = S_BEX;
          OP_J:             state_d = S_JMP;
          OP_ADDI, OP_SLTI: state_d = S_IEX;
          OP_RTYPE: begin
            state_d      = S_REX;
            illegal_inst = ~funct_valid;
          end
          default: begin
            state_d      = S_IF;
            illegal_inst = 1'b1;
          end
        endcase
      end
      S_MA: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        alu_act = 1'b1;
        state_d = (OPcode == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        IorD    = 1'b1;
        mem_rd  = 1'b1;
        mio_req = 1'b1;
        if (MIO_ready) state_d = S_LWB;
      end
      S_LWB: begin
        reg_wr   = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_IF;
      end
      S_MWR: begin
        IorD    = 1'b1;
        mem_wr  = 1'b1;
        mio_req = 1'b1;
        if (MIO_ready) state_d = S_IF;
      end
      S_REX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_REG;
        alu_op  = AOP_FUNCT;
        alu_act = 1'b1;
        // An unsupported funct was already flagged in ID; skip write-back.
        state_d = funct_valid ? S_RWB : S_IF;
      end
      S_RWB: begin
        reg_wr  = 1'b1;
        RegDst  = 1'b1;
        state_d = S_IF;
      end
      S_BEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_REG;
        alu_op     = AOP_SUB;
        alu_act    = 1'b1;
        pc_wr_cond = 1'b1;
        PCSource   = PCSRC_ALUOUT;
        state_d    = S_IF;
      end
      S_JMP: begin
        pc_wr    = 1'b1;
        PCSource = PCSRC_JUMP;
        state_d  = S_IF;
      end
      S_IEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        alu_op  = (OPcode == OP_SLTI) ? AOP_SLT : AOP_ADD;
        alu_act = 1'b1;
        state_d = S_IWB;
      end
      S_IWB: begin
        reg_wr  = 1'b1;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // States that leave the ALU idle present 000 on ALU_Control.
  assign ALU_Control = alu_act ? alu_code : 3'b000;

  // Reset kills every enable and the bus request in the same cycle.
  assign PCWrite     = pc_wr      & ~rst;
  assign PCWriteCond = pc_wr_cond & ~rst;
  assign IRWrite     = ir_wr      & ~rst;
  assign RegWrite    = reg_wr     & ~rst;
  assign MemWrite    = mem_wr     & ~rst;
  assign MemRead     = mem_rd     & ~rst;
  assign CPU_MIO     = mio_req    & ~rst;
  assign state       = state_q;

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Bench for mcpu_ctrl_fsm: directed scenarios plus random instruction streams
// checked against an instruction-level model of the control sequence.
module tb_mcpu_ctrl_fsm;

  localparam int S_IF = 0, S_ID = 1, S_MA = 2, S_MRD = 3, S_LWB = 4, S_MWR = 5;
  localparam int S_REX = 6, S_RWB = 7, S_BEX = 8, S_JMP = 9, S_IEX = 10, S_IWB = 11;
  localparam logic [5:0] OPS [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                     6'b001000, 6'b001010, 6'b000010};
  localparam int         CPI [7] = '{4, 5, 4, 3, 4, 4, 3};
  localparam logic [5:0] FNS [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                     6'b101010, 6'b100111, 6'b000010, 6'b100110};

  logic       clk = 1'b0, rst = 1'b1;
  logic [5:0] OPcode = '0, Fun = '0;
  logic       zero = 1'b0, MIO_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, MemRead;
  logic       IorD, ALUSrcA, RegDst, MemtoReg, CPU_MIO, illegal_inst;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALU_Control;
  logic [3:0] state;
  int total = 0, bad = 0;

  mcpu_ctrl_fsm dut (
    .clk(clk), .rst(rst), .OPcode(OPcode), .Fun(Fun), .zero(zero), .MIO_ready(MIO_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .MemRead(MemRead), .IorD(IorD), .ALUSrcA(ALUSrcA), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .CPU_MIO(CPU_MIO), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALU_Control(ALU_Control), .illegal_inst(illegal_inst), .state(state)
  );

  always #5 clk = ~clk;

  wire [5:0]  en  = {PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, MemRead};
  wire [18:0] act = {PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, MemRead, IorD,
                     ALUSrcA, RegDst, MemtoReg, CPU_MIO, ALUSrcB, PCSource, ALU_Control,
                     illegal_inst};

  // ALU code for a supported funct, -1 otherwise
  function automatic int fn_code(logic [5:0] fn);
    case (fn)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      6'b100111: return 4;
      6'b000010: return 5;
      6'b100110: return 3;
      default:   return -1;
    endcase
  endfunction

  function automatic bit op_ok(logic [5:0] op);
    for (int i = 0; i < 7; i++) if (OPS[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Expected output vector for one cycle, from the per-state output table.
  function automatic logic [18:0] exp_out(int st, logic [5:0] op, logic [5:0] fn, logic rdy);
    logic pcw, pcc, irw, rw, mw, mr, iod, sa, rd, m2r, mio, ill;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    int fc;
    {pcw, pcc, irw, rw, mw, mr, iod, sa, rd, m2r, mio, ill} = '0;
    sb = '0; ps = '0; alu = '0;
    fc = fn_code(fn);
    case (st)
      S_IF:  begin mr = 1; mio = 1; sb = 2'b01; alu = 3'b010; irw = rdy; pcw = rdy; end
      S_ID:  begin sb = 2'b11; alu = 3'b010; ill = !op_ok(op) || (op == 6'b0 && fc < 0); end
      S_MA:  begin sa = 1; sb = 2'b10; alu = 3'b010; end
      S_MRD: begin iod = 1; mr = 1; mio = 1; end
      S_LWB: begin rw = 1; m2r = 1; end
      S_MWR: begin iod = 1; mw = 1; mio = 1; end
      S_REX: begin sa = 1; if (fc >= 0) alu = 3'(fc); end
      S_RWB: begin rw = 1; rd = 1; end
      S_BEX: begin sa = 1; alu = 3'b110; pcc = 1; ps = 2'b01; end
      S_JMP: begin pcw = 1; ps = 2'b10; end
      S_IEX: begin sa = 1; sb = 2'b10; alu = (op == 6'b001010) ? 3'b111 : 3'b010; end
      S_IWB: rw = 1;
      default: ;
    endcase
    return {pcw, pcc, irw, rw, mw, mr, iod, sa, rd, m2r, mio, sb, ps, alu, ill};
  endfunction

  task automatic tick(input logic rdy, input logic [5:0] op, input logic [5:0] fn);
    @(negedge clk);
    MIO_ready = rdy; OPcode = op; Fun = fn;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; MIO_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); MIO_ready = 1'b1; #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if ({en, CPU_MIO} !== 7'b0) begin bad++; $display("FAIL reset_enables got=%b want=0", {en, CPU_MIO}); end
    @(negedge clk); rst = 1'b0; MIO_ready = 1'b0; #1;
    total++; if (act !== 19'b0000010000101000100) begin bad++; $display("FAIL reset_if_outputs got=%b want=0000010000101000100", act); end
    tick(1'b1, 6'b0, 6'b100000);
    total++; if (state !== 4'd0 || {IRWrite, PCWrite} !== 2'b11) begin bad++; $display("FAIL if_ready got st=%0d irw/pcw=%b want st=0 11", state, {IRWrite, PCWrite}); end
    tick(1'b1, 6'b0, 6'b100000);
    total++; if (state !== 4'd1) begin bad++; $display("FAIL if_to_id got=%0d want=1", state); end
  endtask

  task automatic test_sw_wait();
    do_reset();
    tick(1'b1, 6'b101011, 6'b0);
    tick(1'b1, 6'b101011, 6'b0);
    tick(1'b1, 6'b101011, 6'b0);
    total++; if (state !== 4'd2) begin bad++; $display("FAIL sw_ma got=%0d want=2", state); end
    for (int k = 0; k < 4; k++) begin
      tick(k == 3, 6'b101011, 6'b0);
      total++;
      if (state !== 4'd5 || MemWrite !== 1'b1 || RegWrite !== 1'b0) begin
        bad++; $display("FAIL sw_mwr_hold cyc=%0d got st=%0d mw=%b rw=%b want st=5 mw=1 rw=0", k, state, MemWrite, RegWrite);
      end
    end
    tick(1'b1, 6'b101011, 6'b0);
    total++; if (state !== 4'd0) begin bad++; $display("FAIL sw_done got=%0d want=0", state); end
  endtask

  task automatic test_rtype();
    do_reset();
    tick(1'b1, 6'b0, 6'b101010);
    tick(1'b1, 6'b0, 6'b101010);
    total++; if (illegal_inst !== 1'b0) begin bad++; $display("FAIL slt_id_illegal got=%b want=0", illegal_inst); end
    tick(1'b1, 6'b0, 6'b101010);
    total++; if (state !== 4'd6 || ALU_Control !== 3'b111) begin bad++; $display("FAIL slt_rex got st=%0d alu=%b want st=6 alu=111", state, ALU_Control); end
    tick(1'b1, 6'b0, 6'b101010);
    total++; if (state !== 4'd7 || {RegWrite, RegDst} !== 2'b11) begin bad++; $display("FAIL slt_rwb got st=%0d rw/rd=%b want st=7 11", state, {RegWrite, RegDst}); end
    tick(1'b1, 6'b0, 6'b111111);
    tick(1'b1, 6'b0, 6'b111111);
    total++; if (state !== 4'd1 || illegal_inst !== 1'b1) begin bad++; $display("FAIL badfn_id got st=%0d ill=%b want st=1 ill=1", state, illegal_inst); end
    tick(1'b1, 6'b0, 6'b111111);
    total++; if (state !== 4'd6 || RegWrite !== 1'b0 || illegal_inst !== 1'b0) begin bad++; $display("FAIL badfn_rex got st=%0d rw=%b ill=%b want st=6 rw=0 ill=0", state, RegWrite, illegal_inst); end
    tick(1'b1, 6'b0, 6'b111111);
    total++; if (state !== 4'd0 || RegWrite !== 1'b0) begin bad++; $display("FAIL badfn_exit got st=%0d rw=%b want st=0 rw=0", state, RegWrite); end
  endtask

  task automatic test_illegal();
    do_reset();
    tick(1'b1, 6'b111111, 6'b0);
    tick(1'b1, 6'b111111, 6'b0);
    total++; if (state !== 4'd1 || illegal_inst !== 1'b1 || en !== 6'b0) begin bad++; $display("FAIL illop_id got st=%0d ill=%b en=%b want st=1 ill=1 en=0", state, illegal_inst, en); end
    tick(1'b0, 6'b111111, 6'b0);
    total++; if (state !== 4'd0 || illegal_inst !== 1'b0) begin bad++; $display("FAIL illop_next got st=%0d ill=%b want st=0 ill=0", state, illegal_inst); end
  endtask

  task automatic test_rst_mid_wait();
    do_reset();
    tick(1'b1, 6'b100011, 6'b0);
    tick(1'b1, 6'b100011, 6'b0);
    tick(1'b1, 6'b100011, 6'b0);
    tick(1'b0, 6'b100011, 6'b0);
    tick(1'b0, 6'b100011, 6'b0);
    total++; if (state !== 4'd3) begin bad++; $display("FAIL lw_mrd_wait got=%0d want=3", state); end
    @(negedge clk); rst = 1'b1; MIO_ready = 1'b1; #1;
    total++; if ({en, CPU_MIO} !== 7'b0) begin bad++; $display("FAIL rst_mid_wait_en got=%b want=0", {en, CPU_MIO}); end
    @(negedge clk); rst = 1'b0; MIO_ready = 1'b1; #1;
    total++; if (state !== 4'd0 || act !== exp_out(S_IF, OPcode, Fun, 1'b1)) begin bad++; $display("FAIL rst_mid_wait_if got st=%0d out=%b want st=0 out=%b", state, act, exp_out(S_IF, OPcode, Fun, 1'b1)); end
  endtask

  task automatic test_cpi();
    int n;
    do_reset();
    tick(1'b1, 6'b0, 6'b100000);
    total++; if (state !== 4'd0) begin bad++; $display("FAIL cpi_start got=%0d want=0", state); end
    for (int i = 0; i < 7; i++) begin
      n = 1;
      for (int c = 0; c < 20; c++) begin
        tick(1'b1, OPS[i], 6'b100000);
        if (state == 4'd0) break;
        n++;
      end
      total++; if (n !== CPI[i]) begin bad++; $display("FAIL cpi op=%b got=%0d want=%0d", OPS[i], n, CPI[i]); end
    end
  endtask

  task automatic test_random();
    int   qs[$];
    logic qr[$];
    logic [5:0] op, fn;
    int   ifw, mw, r;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      r  = $urandom_range(0, 7);
      op = (r < 7) ? OPS[r] : 6'($urandom);
      r  = $urandom_range(0, 9);
      fn = (r < 8) ? FNS[r] : 6'($urandom);
      ifw = $urandom_range(0, 2);
      mw  = $urandom_range(0, 3);
      qs.delete(); qr.delete();
      repeat (ifw) begin qs.push_back(S_IF); qr.push_back(1'b0); end
      qs.push_back(S_IF); qr.push_back(1'b1);
      qs.push_back(S_ID); qr.push_back(1'($urandom));
      case (op)
        6'b100011: begin
          qs.push_back(S_MA); qr.push_back(1'($urandom));
          repeat (mw) begin qs.push_back(S_MRD); qr.push_back(1'b0); end
          qs.push_back(S_MRD); qr.push_back(1'b1);
          qs.push_back(S_LWB); qr.push_back(1'($urandom));
        end
        6'b101011: begin
          qs.push_back(S_MA); qr.push_back(1'($urandom));
          repeat (mw) begin qs.push_back(S_MWR); qr.push_back(1'b0); end
          qs.push_back(S_MWR); qr.push_back(1'b1);
        end
        6'b000000: begin
          qs.push_back(S_REX); qr.push_back(1'($urandom));
          if (fn_code(fn) >= 0) begin qs.push_back(S_RWB); qr.push_back(1'($urandom)); end
        end
        6'b000100: begin qs.push_back(S_BEX); qr.push_back(1'($urandom)); end
        6'b000010: begin qs.push_back(S_JMP); qr.push_back(1'($urandom)); end
        6'b001000, 6'b001010: begin
          qs.push_back(S_IEX); qr.push_back(1'($urandom));
          qs.push_back(S_IWB); qr.push_back(1'($urandom));
        end
        default: ;
      endcase
      foreach (qs[k]) begin
        tick(qr[k], op, fn);
        total++;
        if (state !== 4'(qs[k])) begin
          bad++; $display("FAIL rnd_state op=%b fn=%b step=%0d got=%0d want=%0d", op, fn, k, state, qs[k]);
        end
        total++;
        if (act !== exp_out(qs[k], op, fn, qr[k])) begin
          bad++; $display("FAIL rnd_outputs op=%b fn=%b st=%0d got=%b want=%b", op, fn, qs[k], act, exp_out(qs[k], op, fn, qr[k]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw_wait();
    test_rtype();
    test_illegal();
    test_rst_mid_wait();
    test_cpi();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
